// File: rtl/spi_ram_ctrl.sv
// Byte RAM with a 2-bit command decoder, fed by the SPI slave's 10-bit parallel word.
// Read data is returned on dout/tx_valid; out-of-order commands are rejected with a cmd_err pulse.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       cmd_err
);

  localparam logic [ADDR_SIZE:0]   DEPTH_L   = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

  typedef enum logic {
    RD_NONE,
    RD_ARMED
  } rd_state_t;

  rd_state_t rd_state, rd_state_nxt;

  logic [7:0]           mem [MEM_DEPTH];
  logic                 rx_valid_q;
  logic                 accept;
  logic [1:0]           opcode;
  logic [ADDR_SIZE-1:0] addr;
  logic                 addr_ok;
  logic [ADDR_SIZE-1:0] wr_addr, wr_addr_nxt;
  logic [ADDR_SIZE-1:0] rd_addr, rd_addr_nxt;
  logic                 wr_addr_vld, wr_addr_vld_nxt;
  logic                 mem_we;
  logic                 rd_fire;
  logic                 err_nxt;

  assign accept  = rx_valid & ~rx_valid_q;
  assign opcode  = din[9:8];
  assign addr    = din[ADDR_SIZE-1:0];
  assign addr_ok = ({1'b0, addr} < DEPTH_L);

  always_comb begin
    rd_state_nxt    = rd_state;
    wr_addr_nxt     = wr_addr;
    rd_addr_nxt     = rd_addr;
    wr_addr_vld_nxt = wr_addr_vld;
    mem_we          = 1'b0;
    rd_fire         = 1'b0;
    err_nxt         = 1'b0;
    if (accept) begin
      unique case (opcode)
        2'b00: begin
          if (addr_ok) begin
            wr_addr_nxt     = addr;
            wr_addr_vld_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
        2'b01: begin
          if (wr_addr_vld) begin
            mem_we = 1'b1;
            if (AUTO_INC != 0) begin
              wr_addr_nxt = (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_SIZE'(1);
            end
          end else begin
            err_nxt = 1'b1;
          end
        end
        2'b10: begin
          if (addr_ok) begin
            rd_addr_nxt  = addr;
            rd_state_nxt = RD_ARMED;
          end else begin
            err_nxt = 1'b1;
          end
        end
        default: begin
          if (rd_state == RD_ARMED) begin
            rd_fire      = 1'b1;
            rd_state_nxt = RD_NONE;
          end else begin
            err_nxt = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q  <= 1'b0;
      rd_state    <= RD_NONE;
      wr_addr     <= '0;
      rd_addr     <= '0;
      wr_addr_vld <= 1'b0;
      cmd_err     <= 1'b0;
      tx_valid    <= 1'b0;
      dout        <= '0;
    end else begin
      rx_valid_q  <= rx_valid;
      rd_state    <= rd_state_nxt;
      wr_addr     <= wr_addr_nxt;
      rd_addr     <= rd_addr_nxt;
      wr_addr_vld <= wr_addr_vld_nxt;
      cmd_err     <= err_nxt;
      // Any accepted command ends the previous read's tx_valid window.
      if (rd_fire) begin
        tx_valid <= 1'b1;
        dout     <= mem[rd_addr];
      end else if (accept) begin
        tx_valid <= 1'b0;
      end
    end
  end

  // Storage has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= din[7:0];
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Randomized self-checking bench for spi_ram_ctrl: two instances (depth 200 no auto-inc,
// depth 256 with auto-inc) driven in parallel and compared against an array-based model.
module tb_spi_ram_ctrl;

  logic       clk;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout_w [2];
  logic       tx_w   [2];
  logic       err_w  [2];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_SIZE(8), .AUTO_INC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout_w[0]), .tx_valid(tx_w[0]), .cmd_err(err_w[0])
  );

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout_w[1]), .tx_valid(tx_w[1]), .cmd_err(err_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, one slot per instance.
  int          m_depth [2] = '{200, 256};
  bit          m_inc   [2] = '{1'b0, 1'b1};
  logic [7:0]  m_mem   [2][256];
  int          m_wa    [2];
  int          m_ra    [2];
  bit          m_wv    [2];
  bit          m_arm   [2];
  logic [7:0]  e_dout  [2];
  bit          e_tx    [2];
  bit          e_err   [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s[%0d].dout", tag, i), 32'(dout_w[i]), 32'(e_dout[i]));
      check_eq($sformatf("%s[%0d].tx_valid", tag, i), 32'(tx_w[i]), 32'(e_tx[i]));
      check_eq($sformatf("%s[%0d].cmd_err", tag, i), 32'(err_w[i]), 32'(e_err[i]));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wa[i] = 0; m_ra[i] = 0; m_wv[i] = 1'b0; m_arm[i] = 1'b0;
      e_dout[i] = 8'h00; e_tx[i] = 1'b0; e_err[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit acc, input logic [9:0] d);
    int a;
    a = int'(d[7:0]);
    for (int i = 0; i < 2; i++) begin
      e_err[i] = 1'b0;
      if (acc) begin
        e_tx[i] = 1'b0;
        case (d[9:8])
          2'b00: if (a < m_depth[i]) begin m_wa[i] = a; m_wv[i] = 1'b1; end
                 else e_err[i] = 1'b1;
          2'b01: if (m_wv[i]) begin
                   m_mem[i][m_wa[i]] = d[7:0];
                   if (m_inc[i]) m_wa[i] = (m_wa[i] + 1) % m_depth[i];
                 end else e_err[i] = 1'b1;
          2'b10: if (a < m_depth[i]) begin m_ra[i] = a; m_arm[i] = 1'b1; end
                 else e_err[i] = 1'b1;
          default: if (m_arm[i]) begin
                     e_dout[i] = m_mem[i][m_ra[i]]; e_tx[i] = 1'b1; m_arm[i] = 1'b0;
                   end else e_err[i] = 1'b1;
        endcase
      end
    end
  endtask

  // Holds rx_valid for 'hold' edges, then drops it for one idle edge.
  task automatic send(input logic [9:0] d, input int unsigned hold);
    din = d;
    rx_valid = 1'b1;
    for (int unsigned c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      model_edge(c == 0, d);
      check_all("cmd");
    end
    rx_valid = 1'b0;
    @(posedge clk); #1;
    model_edge(1'b0, d);
    check_all("idle");
  endtask

  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    check_all("in_rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("post_rst");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    din = '0;
    rx_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("reset_rel");

    // Out-of-order commands straight after reset.
    send(10'h1_55, 1);
    send(10'h3_00, 1);

    // Fill every location so later reads are fully defined.
    for (int a = 0; a < 256; a++) begin
      send({2'b00, 8'(a)}, 1);
      send({2'b01, 8'($urandom_range(255))}, 1);
    end

    send(10'h0_A5, 1);
    send(10'h1_3C, 1);
    send(10'h2_A5, 1);
    send(10'h3_00, 1);
    check_eq("read_a5.dout", 32'(dout_w[1]), 32'h3C);
    send(10'h0_01, 1);

    // Held rx_valid must produce exactly one write.
    send(10'h0_10, 1);
    send(10'h1_77, 5);
    send(10'h1_88, 1);
    send(10'h2_10, 1);
    send(10'h3_00, 3);
    check_eq("hold_10.dout", 32'(dout_w[1]), 32'h77);
    send(10'h2_11, 1);
    send(10'h3_00, 1);
    check_eq("inc_11.dout", 32'(dout_w[1]), 32'h88);

    // Auto-increment wrap at the top of memory.
    send(10'h0_FF, 1);
    send(10'h1_11, 1);
    send(10'h1_22, 1);
    send(10'h2_FF, 1);
    send(10'h3_00, 1);
    send(10'h2_00, 1);
    send(10'h3_00, 1);
    check_eq("wrap_00.dout", 32'(dout_w[1]), 32'h22);

    // Reset while tx_valid is high, then confirm memory retention.
    send(10'h2_A5, 1);
    send(10'h3_00, 1);
    async_reset();
    send(10'h3_00, 1);
    send(10'h2_A5, 1);
    send(10'h3_00, 1);
    check_eq("retain_a5.dout", 32'(dout_w[1]), 32'h3C);

    for (int n = 0; n < 400; n++) begin
      send(10'($urandom_range(1023)), $urandom_range(1, 4));
      if ($urandom_range(3) == 0) begin
        @(posedge clk); #1;
        model_edge(1'b0, din);
        check_all("gap");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Single-port byte RAM with command decoder; sits directly downstream of the SPI slave.
- Consumes the slave's 10-bit parallel word (rx_data/rx_valid) as a command plus payload.
- Returns read bytes to the slave on dout/tx_valid for serialisation on MISO.
- Tracks write/read address ownership so out-of-order commands are rejected and flagged, not silently executed.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words.
- ADDR_SIZE, 8, address width; must be ≤ 8 and 2**ADDR_SIZE ≥ MEM_DEPTH.
- AUTO_INC, 0, if 1 the write address increments after each accepted write-data command.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  10  command word from the SPI slave: [9:8] opcode, [7:0] payload.
- rx_valid  input  1  din valid; the slave may hold it high for several cycles.
- dout  output  8  read data to the SPI slave.
- tx_valid  output  1  dout valid; held until the next accepted command.
- cmd_err  output  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset (async, rst_n low):
  - dout=0, tx_valid=0, cmd_err=0.
  - wr_addr=0, rd_addr=0, wr_addr_vld=0; read FSM goes to RD_NONE.
  - rx_valid_q=0.
  - Memory contents are NOT reset and are retained across reset.
- Acceptance:
  - A command is accepted only on the clk edge where rx_valid=1 and rx_valid_q=0 (rising-edge detect). rx_valid_q is rx_valid registered.
  - Holding rx_valid high never re-executes the same command.
  - din is sampled on the accept edge only.
- Address mapping: addr = din[ADDR_SIZE-1:0]. An address ≥ MEM_DEPTH is rejected (cmd_err pulse, no state change).
- Opcode 2'b00, write-address:
  - wr_addr <= addr; wr_addr_vld <= 1.
- Opcode 2'b01, write-data:
  - If wr_addr_vld: mem[wr_addr] <= din[7:0].
  - If also AUTO_INC=1: wr_addr <= wr_addr+1, wrapping MEM_DEPTH-1 → 0.
  - If !wr_addr_vld: cmd_err pulse, memory unchanged.
- Opcode 2'b10, read-address:
  - rd_addr <= addr; read FSM → RD_ARMED.
- Opcode 2'b11, read-data:
  - In RD_ARMED: dout <= mem[rd_addr], tx_valid <= 1, FSM → RD_NONE. The address is consumed; a second read-data needs a new read-address.
  - In RD_NONE: cmd_err pulse, dout unchanged, tx_valid stays 0.
  - din[7:0] is ignored.
- Read FSM: RD_NONE --op10--> RD_ARMED --op11--> RD_NONE. An op10 while RD_ARMED re-arms with the new address.
- tx_valid:
  - Rises on the edge after an accepted read-data (latency 1 cycle from the accept edge).
  - Stays high, with dout stable, until the next accepted command of any opcode; it clears on that accept edge.
  - dout holds its last value after tx_valid falls.
- cmd_err: high for exactly one cycle after the rejecting accept edge; never asserted otherwise.
- Simultaneous events:
  - Write-data to the address that is currently rd_addr: the read-data that follows returns the new data.
  - Reset during tx_valid=1 drops tx_valid immediately (asynchronous).
- Write-address does not disturb read state, and vice versa.
- Single clock domain; no combinational path from din/rx_valid to any output.

Test Plan:
- Reset, then rx_valid pulse with din=10'h0_A5 followed by din=10'h1_3C (write 0x3C at 0xA5) → no cmd_err, mem[0xA5]=0x3C.
- din=10'h2_A5, then din=10'h3_00 → one cycle after the second accept, tx_valid=1 and dout=0x3C. tx_valid stays 1 until the next rx_valid rising edge, then drops.
- Write-data din=10'h1_55 immediately after reset, with no write-address → cmd_err one-cycle pulse, no memory location changes. Repeat with read-data din=10'h3_00 → cmd_err pulse, tx_valid stays 0.
- Hold rx_valid high for 5 cycles with din=10'h1_77 after write-address 0x10, AUTO_INC=1 → exactly one write (mem[0x10]=0x77), wr_addr becomes 0x11.
- AUTO_INC=1, write-address 0xFF, then two write-data 0x11 and 0x22 → mem[0xFF]=0x11, mem[0x00]=0x22 (wrap).
- Issue a read cycle to reach tx_valid=1, assert rst_n=0 mid-hold → tx_valid=0 and dout=0 immediately. After release, read-data without read-address → cmd_err pulse; a prior write still reads back correctly after re-arming.
